// File: rtl/next_pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Turns the control-transfer selection into the next PC.
// Fetches the instruction at PC over a request/grant/response interface.
// Holds the instruction valid until it retires.
// Misaligned branch and JALR targets are redirected to TRAP_VECTOR.
module next_pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0040_0100
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] pc_imm,
  input  logic [31:0] jalr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misaligned_trap,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT    = 2'd2,
    ST_EXECUTE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        trap_q, trap_d;

  logic [31:0] target;
  logic        misaligned;

  // Raw control-transfer target for the current selection (modulo 2^32).
  function automatic logic [31:0] calc_target(input logic [1:0]  sel,
                                              input logic [31:0] cur_pc,
                                              input logic [31:0] imm,
                                              input logic [31:0] jalr);
    logic signed [31:0] pc_s;
    logic signed [31:0] imm_s;
    pc_s  = cur_pc;
    imm_s = imm;
    case (sel)
      2'b00:   calc_target = cur_pc + 32'd4;
      2'b01:   calc_target = 32'(pc_s + imm_s);
      2'b10:   calc_target = jalr & ~32'h1;
      default: calc_target = TRAP_VECTOR;
    endcase
  endfunction

  // Only PC-relative and register-indirect targets can be misaligned.
  function automatic logic is_misaligned(input logic [1:0]  sel,
                                         input logic [31:0] tgt);
    is_misaligned = ((sel == 2'b01) || (sel == 2'b10)) && tgt[1];
  endfunction

  assign target     = calc_target(next_pc_select, pc_q, pc_imm, jalr_target);
  assign misaligned = is_misaligned(next_pc_select, target);

  // State and datapath registers; reset aborts any fetch in flight.
  // armed_q holds the FSM in IDLE for one extra edge after reset release,
  // so the first request goes out on the second edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      pc_q         <= RESET_VECTOR;
      inst_q       <= NOP;
      fault_addr_q <= 32'h0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      fault_addr_q <= fault_addr_d;
      trap_q       <= trap_d;
    end
  end

  // Next-state logic; stray responses and retires are ignored by state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (armed_q)     state_d = ST_REQUEST;
      ST_REQUEST: if (imem_gnt)    state_d = ST_WAIT;
      ST_WAIT:    if (imem_rvalid) state_d = ST_EXECUTE;
      ST_EXECUTE: if (retire)      state_d = ST_REQUEST;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: capture the response in WAIT, redirect PC on retire.
  always_comb begin
    armed_d      = 1'b1;
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_addr_d = fault_addr_q;
    trap_d       = 1'b0;
    if ((state_q == ST_WAIT) && imem_rvalid) begin
      inst_d = imem_rdata;
    end
    if ((state_q == ST_EXECUTE) && retire) begin
      pc_d   = misaligned ? TRAP_VECTOR : target;
      trap_d = misaligned;
      if (misaligned) begin
        fault_addr_d = target;
      end
    end
  end

  // Outputs decoded from state or taken directly from registers.
  always_comb begin
    imem_req        = (state_q == ST_REQUEST);
    inst_valid      = (state_q == ST_EXECUTE);
    imem_addr       = pc_q;
    pc              = pc_q;
    pc_plus_4       = pc_q + 32'd4;
    inst            = inst_q;
    misaligned_trap = trap_q;
    fault_addr      = fault_addr_q;
  end

endmodule

// File: tb/tb_next_pc_fetch.sv
// Self-checking bench for next_pc_fetch: directed table, corner sequences,
// and randomized fetch/retire traffic against a reference model.
module tb_next_pc_fetch;

  localparam logic [31:0] RV   = 32'h0040_0000;
  localparam logic [31:0] TV   = 32'h0040_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  sel;
  logic [31:0] imm, jalr;
  logic        retire;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, pc_plus_4, inst, fault_addr;
  logic        inst_valid, misaligned_trap;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_fault;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] jalr;
    logic [31:0] exp_pc;
    logic [31:0] exp_fault;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[9];

  next_pc_fetch #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clock(clock), .reset_n(reset_n), .next_pc_select(sel), .pc_imm(imm),
    .jalr_target(jalr), .retire(retire), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc(pc), .pc_plus_4(pc_plus_4), .inst(inst),
    .inst_valid(inst_valid), .misaligned_trap(misaligned_trap),
    .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Architectural model of one retire: select rule, 32-bit wrap, trap rule.
  task automatic model_retire(input logic [1:0] s, input logic [31:0] im,
                              input logic [31:0] jr, output logic [31:0] npc,
                              output logic [31:0] nfault, output logic ntrap);
    logic [31:0] t;
    case (s)
      2'd0:    t = m_pc + 32'd4;
      2'd1:    t = m_pc + im;
      2'd2:    t = jr - (jr % 2);
      default: t = TV;
    endcase
    ntrap  = (s == 2'd1 || s == 2'd2) && ((t / 2) % 2 == 1);
    npc    = ntrap ? TV : t;
    nfault = ntrap ? t : m_fault;
  endtask

  // One fetch: grant after gdly cycles, response rdly cycles after grant.
  // Stray rvalid/retire are driven while not in EXECUTE and must be ignored.
  task automatic fetch(input logic [31:0] data, input int gdly, input int rdly);
    int n  = 0;
    int hi = 0;
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < gdly; i++) begin
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = ~data;
      retire = 1'b1; sel = 2'($urandom_range(0, 3));
      if (imem_req) hi++;
      step();
    end
    if (imem_req) hi++;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; retire = 1'b0;
    step();
    imem_gnt = 1'b0;
    chk("req_hold_cycles", 32'(hi), 32'(gdly + 1));
    chk("wait_req_low", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdly; i++) begin
      retire = 1'b1; sel = 2'($urandom_range(0, 3));
      step();
      chk("wait_not_valid", {31'd0, inst_valid}, 32'd0);
    end
    retire = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
    step();
    imem_rvalid = 1'b0;
    chk("fetch_valid", {31'd0, inst_valid}, 32'd1);
    chk("fetch_inst", inst, data);
    chk("fetch_pc", pc, m_pc);
    chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
  endtask

  task automatic do_retire(input logic [1:0] s, input logic [31:0] im, input logic [31:0] jr,
                           input logic [31:0] epc, input logic [31:0] efault, input logic etrap);
    chk("pre_retire_valid", {31'd0, inst_valid}, 32'd1);
    sel = s; imm = im; jalr = jr; retire = 1'b1;
    step();
    retire = 1'b0;
    chk("retire_valid_low", {31'd0, inst_valid}, 32'd0);
    chk("retire_req_high", {31'd0, imem_req}, 32'd1);
    chk("retire_pc", pc, epc);
    chk("retire_trap", {31'd0, misaligned_trap}, {31'd0, etrap});
    chk("retire_fault", fault_addr, efault);
    step();
    chk("trap_one_cycle", {31'd0, misaligned_trap}, 32'd0);
    m_pc = epc;
    m_fault = efault;
  endtask

  initial begin
    logic [31:0] d, npc, nf;
    logic        nt;
    logic [1:0]  rs;
    logic [31:0] ri, rj;

    reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    retire = 1'b0; sel = 2'd0; imm = 32'h0; jalr = 32'h0;

    vecs[0] = '{2'b00, 32'h0,         32'h0,         32'h0040_0004, 32'h0,         1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFF8, 32'h0,         32'h003F_FFFC, 32'h0,         1'b0};
    vecs[2] = '{2'b10, 32'h0,         32'h0040_0021, 32'h0040_0020, 32'h0,         1'b0};
    vecs[3] = '{2'b01, 32'h6,         32'h0,         TV,            32'h0040_0026, 1'b1};
    vecs[4] = '{2'b11, 32'h0,         32'h0,         TV,            32'h0040_0026, 1'b0};
    vecs[5] = '{2'b10, 32'h0,         32'h0040_0103, TV,            32'h0040_0102, 1'b1};
    vecs[6] = '{2'b10, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0040_0102, 1'b0};
    vecs[7] = '{2'b00, 32'h0,         32'h0,         32'h0000_0000, 32'h0040_0102, 1'b0};
    vecs[8] = '{2'b01, 32'h10,        32'h0,         32'h0000_0010, 32'h0040_0102, 1'b0};

    repeat (3) step();
    chk("rst_pc", pc, RV);
    chk("rst_inst", inst, NOP);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_trap", {31'd0, misaligned_trap}, 32'd0);
    chk("rst_fault", fault_addr, 32'h0);

    // First fetch after release: request on 2nd edge, valid on 4th.
    reset_n = 1'b1; imem_gnt = 1'b1; m_pc = RV; m_fault = 32'h0;
    step();
    chk("t1_req_edge1", {31'd0, imem_req}, 32'd0);
    step();
    chk("t1_req_edge2", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, RV);
    step();
    imem_gnt = 1'b0;
    chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
    chk("t1_wait_valid", {31'd0, inst_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk("t1_valid_edge4", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h0050_0093);

    for (int i = 0; i < 9; i++) begin
      do_retire(vecs[i].sel, vecs[i].imm, vecs[i].jalr,
                vecs[i].exp_pc, vecs[i].exp_fault, vecs[i].exp_trap);
      fetch($urandom, 0, 0);
    end

    // Grant withheld 3 cycles, then a spurious response in EXECUTE.
    do_retire(2'b00, 32'h0, 32'h0, 32'h0000_0014, m_fault, 1'b0);
    d = 32'h1234_5678;
    fetch(d, 3, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("t5_inst_held", inst, d);
    chk("t5_valid_held", {31'd0, inst_valid}, 32'd1);
    chk("t5_pc_held", pc, 32'h0000_0014);

    // Reset during WAIT; a late response in IDLE must be discarded.
    do_retire(2'b00, 32'h0, 32'h0, 32'h0000_0018, m_fault, 1'b0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("t6_in_wait", {31'd0, imem_req}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t6_async_pc", pc, RV);
    chk("t6_async_inst", inst, NOP);
    chk("t6_async_fault", fault_addr, 32'h0);
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    step();
    reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    step();
    imem_rvalid = 1'b0;
    chk("t6_stale_ignored", inst, NOP);
    chk("t6_not_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_refetch_addr", imem_addr, RV);
    m_pc = RV; m_fault = 32'h0;
    fetch(32'hCAFE_0001, 1, 1);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 150; it++) begin
      rs = 2'($urandom_range(0, 3));
      ri = 32'($urandom_range(0, 64)) - 32'd32;
      rj = $urandom;
      model_retire(rs, ri, rj, npc, nf, nt);
      do_retire(rs, ri, rj, npc, nf, nt);
      d = $urandom;
      fetch(d, $urandom_range(0, 3), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        imem_rvalid = 1'b1; imem_rdata = $urandom;
        step();
        imem_rvalid = 1'b0;
        chk("rand_inst_held", inst, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
